// File: rtl/if_id_stage.sv
// IF/ID pipeline register with instruction field decode in front of the register.
// Define IF_ID_ILLEGAL_EN to flag unsupported opcodes on id_illegal.
module if_id_stage #(
    parameter int unsigned PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_ready,
    input  logic            id_stall,
    input  logic            id_flush,
    output logic            id_valid,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [5:0]      id_opcode,
    output logic [4:0]      id_rs,
    output logic [4:0]      id_rt,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_shamt,
    output logic [5:0]      id_funct,
    output logic [15:0]     id_imm16,
    output logic            id_sign_ext,
    output logic [4:0]      id_dest,
    output logic            id_reg_write,
    output logic            id_illegal
);

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_J       = 6'h02,
        OP_JAL     = 6'h03,
        OP_BEQ     = 6'h04,
        OP_BNE     = 6'h05,
        OP_ADDI    = 6'h08,
        OP_ADDIU   = 6'h09,
        OP_SLTI    = 6'h0A,
        OP_SLTIU   = 6'h0B,
        OP_ANDI    = 6'h0C,
        OP_ORI     = 6'h0D,
        OP_XORI    = 6'h0E,
        OP_LUI     = 6'h0F,
        OP_LB      = 6'h20,
        OP_LH      = 6'h21,
        OP_LW      = 6'h23,
        OP_LBU     = 6'h24,
        OP_LHU     = 6'h25,
        OP_SB      = 6'h28,
        OP_SH      = 6'h29,
        OP_SW      = 6'h2B
    } opcode_e;

    typedef enum logic [1:0] {
        ACT_BUBBLE,
        ACT_LOAD,
        ACT_HOLD,
        ACT_FLUSH
    } action_e;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [5:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [5:0]      funct;
        logic [15:0]     imm16;
        logic            sign_ext;
        logic [4:0]      dest;
        logic            reg_write;
        logic            illegal;
    } stage_t;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    stage_t  stage_q;
    stage_t  load_d;
    stage_t  clear_d;
    action_e action;

    logic       dec_supported;
    logic       dec_sign_ext;
    logic [4:0] dec_dest;
    logic       dec_writes;

    assign if_ready = ~id_flush & (~stage_q.valid | ~id_stall);

    always_comb begin
        if (id_flush) begin
            action = ACT_FLUSH;
        end else if (stage_q.valid && id_stall) begin
            action = ACT_HOLD;
        end else if (if_valid && if_ready) begin
            action = ACT_LOAD;
        end else begin
            action = ACT_BUBBLE;
        end
    end

    always_comb begin
        dec_supported = 1'b1;
        dec_sign_ext  = 1'b0;
        dec_dest      = '0;
        dec_writes    = 1'b0;
        case (if_instr[31:26])
            OP_SPECIAL: begin
                dec_dest   = if_instr[15:11];
                dec_writes = (if_instr[5:0] != FUNCT_JR);
            end
            OP_JAL: begin
                dec_dest   = 5'd31;
                dec_writes = 1'b1;
            end
            OP_J: ;
            OP_BEQ, OP_BNE: begin
                dec_sign_ext = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec_sign_ext = 1'b1;
                dec_dest     = if_instr[20:16];
                dec_writes   = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec_dest   = if_instr[20:16];
                dec_writes = 1'b1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec_sign_ext = 1'b1;
                dec_dest     = if_instr[20:16];
                dec_writes   = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                dec_sign_ext = 1'b1;
            end
            default: begin
                dec_supported = 1'b0;
            end
        endcase
    end

    always_comb begin
        load_d           = '0;
        load_d.valid     = 1'b1;
        load_d.pc        = if_pc;
        load_d.instr     = if_instr;
        load_d.opcode    = if_instr[31:26];
        load_d.rs        = if_instr[25:21];
        load_d.rt        = if_instr[20:16];
        load_d.rd        = if_instr[15:11];
        load_d.shamt     = if_instr[10:6];
        load_d.funct     = if_instr[5:0];
        load_d.imm16     = if_instr[15:0];
        load_d.sign_ext  = dec_sign_ext;
        load_d.dest      = dec_dest;
        // $0 is never a real destination, so writes to it are suppressed here
        load_d.reg_write = dec_writes & dec_supported & (dec_dest != 5'd0);
`ifdef IF_ID_ILLEGAL_EN
        load_d.illegal   = ~dec_supported;
`else
        load_d.illegal   = 1'b0;
`endif
    end

    always_comb begin
        clear_d       = '0;
        clear_d.instr = NOP_INSTR;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= clear_d;
        end else begin
            case (action)
                ACT_LOAD:   stage_q <= load_d;
                ACT_HOLD:   stage_q <= stage_q;
                default:    stage_q <= clear_d;
            endcase
        end
    end

    assign id_valid     = stage_q.valid;
    assign id_pc        = stage_q.pc;
    assign id_instr     = stage_q.instr;
    assign id_opcode    = stage_q.opcode;
    assign id_rs        = stage_q.rs;
    assign id_rt        = stage_q.rt;
    assign id_rd        = stage_q.rd;
    assign id_shamt     = stage_q.shamt;
    assign id_funct     = stage_q.funct;
    assign id_imm16     = stage_q.imm16;
    assign id_sign_ext  = stage_q.sign_ext;
    assign id_dest      = stage_q.dest;
    assign id_reg_write = stage_q.reg_write;
    assign id_illegal   = stage_q.illegal;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: stimulus pushes expected stage contents per edge,
// a monitor on the falling edge pops and compares.
module tb_if_id_stage;

    localparam int unsigned PC_W = 32;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc;
    logic            if_ready;
    logic            id_stall;
    logic            id_flush;
    logic            id_valid;
    logic [PC_W-1:0] id_pc;
    logic [31:0]     id_instr;
    logic [5:0]      id_opcode;
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic [4:0]      id_rd;
    logic [4:0]      id_shamt;
    logic [5:0]      id_funct;
    logic [15:0]     id_imm16;
    logic            id_sign_ext;
    logic [4:0]      id_dest;
    logic            id_reg_write;
    logic            id_illegal;

    if_id_stage #(.PC_W(PC_W), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready), .id_stall(id_stall), .id_flush(id_flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct),
        .id_imm16(id_imm16), .id_sign_ext(id_sign_ext), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [5:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [5:0]      funct;
        logic [15:0]     imm16;
        logic            sign_ext;
        logic [4:0]      dest;
        logic            reg_write;
        logic            illegal;
    } rec_t;

    typedef enum int {CL_BAD, CL_R, CL_J, CL_JAL, CL_BR, CL_ALUI_S, CL_ALUI_Z, CL_LD, CL_ST} cls_e;

    cls_e cls_tab [64];
    rec_t exp_q [$];
    rec_t model;
    int   errors = 0;
    int   checks = 0;

    function automatic rec_t empty_rec();
        rec_t r = '0;
        r.instr = NOP;
        return r;
    endfunction

    function automatic rec_t expect_load(input logic [31:0] ins, input logic [PC_W-1:0] pc);
        rec_t r = '0;
        cls_e c = cls_tab[ins[31:26]];
        logic wr;
        r.valid  = 1'b1;
        r.pc     = pc;
        r.instr  = ins;
        r.opcode = ins[31:26];
        r.rs     = ins[25:21];
        r.rt     = ins[20:16];
        r.rd     = ins[15:11];
        r.shamt  = ins[10:6];
        r.funct  = ins[5:0];
        r.imm16  = ins[15:0];
        r.sign_ext = (c == CL_BR) || (c == CL_ALUI_S) || (c == CL_LD) || (c == CL_ST);
        case (c)
            CL_R:                         r.dest = ins[15:11];
            CL_JAL:                       r.dest = 5'd31;
            CL_ALUI_S, CL_ALUI_Z, CL_LD:  r.dest = ins[20:16];
            default:                      r.dest = 5'd0;
        endcase
        wr = (c == CL_R && ins[5:0] != 6'h08) || c == CL_JAL || c == CL_ALUI_S
             || c == CL_ALUI_Z || c == CL_LD;
        r.reg_write = wr && (r.dest != 5'd0);
`ifdef IF_ID_ILLEGAL_EN
        r.illegal = (c == CL_BAD);
`else
        r.illegal = 1'b0;
`endif
        return r;
    endfunction

    // Apply inputs over one rising edge and record what the stage should hold afterwards.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                         input logic stall, input logic flush);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
        id_stall = stall;
        id_flush = flush;
        @(posedge clk);
        if (!rst_n)                      model = empty_rec();
        else if (id_flush)               model = empty_rec();
        else if (model.valid && id_stall) model = model;
        else if (if_valid)               model = expect_load(if_instr, if_pc);
        else                             model = empty_rec();
        exp_q.push_back(model);
        #1;
    endtask

    initial begin
        rec_t e;
        rec_t act;
        logic exp_ready;
        @(posedge clk);
        forever begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow t=%0t got=empty required=entry", $time);
            end else begin
                e = exp_q.pop_front();
                act = '{id_valid, id_pc, id_instr, id_opcode, id_rs, id_rt, id_rd, id_shamt,
                        id_funct, id_imm16, id_sign_ext, id_dest, id_reg_write, id_illegal};
                if (act !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got=%h required=%h (valid %b/%b dest %0d/%0d wr %b/%b se %b/%b ill %b/%b)",
                             $time, act, e, act.valid, e.valid, act.dest, e.dest,
                             act.reg_write, e.reg_write, act.sign_ext, e.sign_ext,
                             act.illegal, e.illegal);
                end
                checks++;
                exp_ready = ~id_flush & (~e.valid | ~id_stall);
                if (if_ready !== exp_ready) begin
                    errors++;
                    $display("FAIL if_ready t=%0t got=%b required=%b", $time, if_ready, exp_ready);
                end
            end
        end
    end

    initial begin
        logic [5:0]  ops [25];
        logic [31:0] ins;
        for (int i = 0; i < 64; i++) cls_tab[i] = CL_BAD;
        cls_tab[6'h00] = CL_R;
        cls_tab[6'h02] = CL_J;
        cls_tab[6'h03] = CL_JAL;
        cls_tab[6'h04] = CL_BR;      cls_tab[6'h05] = CL_BR;
        cls_tab[6'h08] = CL_ALUI_S;  cls_tab[6'h09] = CL_ALUI_S;
        cls_tab[6'h0A] = CL_ALUI_S;  cls_tab[6'h0B] = CL_ALUI_S;
        cls_tab[6'h0C] = CL_ALUI_Z;  cls_tab[6'h0D] = CL_ALUI_Z;
        cls_tab[6'h0E] = CL_ALUI_Z;  cls_tab[6'h0F] = CL_ALUI_Z;
        cls_tab[6'h20] = CL_LD; cls_tab[6'h21] = CL_LD; cls_tab[6'h23] = CL_LD;
        cls_tab[6'h24] = CL_LD; cls_tab[6'h25] = CL_LD;
        cls_tab[6'h28] = CL_ST; cls_tab[6'h29] = CL_ST; cls_tab[6'h2B] = CL_ST;
        ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28,
                6'h29, 6'h2B, 6'h3F, 6'h01, 6'h06};
        model = empty_rec();

        // Reset with a valid fetch present must still leave the stage empty.
        rst_n = 1'b0;
        drive(1'b1, 32'h2128_FFFF, 32'h40, 1'b0, 1'b0);
        rst_n = 1'b1;

        drive(1'b1, 32'h2128_FFFF, 32'h40, 1'b0, 1'b0);   // addi $8,$9,-1
        drive(1'b1, 32'h3508_8000, 32'h44, 1'b0, 1'b0);   // ori $8,$8,0x8000
        drive(1'b1, 32'h0109_5020, 32'h48, 1'b0, 1'b0);   // add $10,$8,$9
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h8D28_0004, 32'h4C, 1'b1, 1'b0);
        drive(1'b1, 32'h8D28_0004, 32'h4C, 1'b0, 1'b0);   // lw released after stall
        drive(1'b1, 32'hAD28_0008, 32'h50, 1'b1, 1'b1);   // flush beats stall and load
        drive(1'b1, 32'hFC00_0000, 32'h54, 1'b0, 1'b0);   // opcode 3F
        drive(1'b1, 32'h03E0_0008, 32'h58, 1'b0, 1'b0);   // jr $31
        drive(1'b1, 32'h0C00_0010, 32'h5C, 1'b0, 1'b0);   // jal
        drive(1'b1, 32'h2000_0005, 32'h60, 1'b0, 1'b0);   // addi $0 -> no write
        drive(1'b0, 32'h2128_FFFF, 32'h64, 1'b0, 1'b0);   // bubble
        drive(1'b1, 32'h1109_0003, 32'h68, 1'b1, 1'b0);   // stall on empty stage still loads
        drive(1'b0, 32'h0, 32'h6C, 1'b1, 1'b0);           // held

        for (int n = 0; n < 500; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 24)];
            if ($urandom_range(0, 3) == 0) ins[5:0] = 6'h08;
            if ($urandom_range(0, 4) == 0) ins[20:11] = '0;
            rst_n = ($urandom_range(0, 49) != 0);
            drive($urandom_range(0, 9) < 7, ins, {$urandom} & ~32'h3,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
        end
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
